// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM/WB pipeline register with write-back select, load extraction and retire counter
// Optional feature macro: WB_LOAD_EXT_EN (sub-word load extraction with sign/zero extension)
module mem_wb_stage #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic               in_reg_write,
  input  logic [RADDR_W-1:0] in_rd,
  input  logic [1:0]         in_wb_sel,
  input  logic [XLEN-1:0]    in_alu_result,
  input  logic [XLEN-1:0]    in_mem_data,
  input  logic [XLEN-1:0]    in_pc_plus4,
  input  logic [XLEN-1:0]    in_imm,
  input  logic [2:0]         in_funct3,
  input  logic [1:0]         in_addr_lo,
  input  logic               stall,
  input  logic               flush,
  output logic               rf_we,
  output logic [RADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]    rf_wdata,
  output logic [XLEN-1:0]    retire_count
);

  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] wb_data;

`ifdef WB_LOAD_EXT_EN
  // Sub-word lanes always come from the low 32 bits; narrower datapaths are zero-padded
  logic [31:0] mem_lo;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  generate
    if (XLEN >= 32) begin : g_mem_wide
      assign mem_lo = in_mem_data[31:0];
    end else begin : g_mem_narrow
      assign mem_lo = {{(32-XLEN){1'b0}}, in_mem_data};
    end
  endgenerate

  // Byte lane picked by full low address; halfword lane ignores address bit 0
  always_comb begin
    byte_v = mem_lo[{in_addr_lo, 3'b000} +: 8];
    half_v = mem_lo[{in_addr_lo[1], 4'b0000} +: 16];
  end

  // Load size/sign decode; unknown codes fall back to the full word
  always_comb begin
    load_data = in_mem_data;
    case (in_funct3)
      3'b000:  load_data = XLEN'($signed(byte_v));
      3'b100:  load_data = XLEN'(byte_v);
      3'b001:  load_data = XLEN'($signed(half_v));
      3'b101:  load_data = XLEN'(half_v);
      default: load_data = in_mem_data;
    endcase
  end
`else
  // Without sub-word extraction the load size and address bits have no effect
  logic unused_load_ctrl;
  assign unused_load_ctrl = ^{in_funct3, in_addr_lo};

  // Memory data is written back unmodified
  always_comb begin
    load_data = in_mem_data;
  end
`endif

  // Write-back source select
  always_comb begin
    wb_data = in_alu_result;
    case (in_wb_sel)
      2'b00:   wb_data = in_alu_result;
      2'b01:   wb_data = load_data;
      2'b10:   wb_data = in_pc_plus4;
      default: wb_data = in_imm;
    endcase
  end

  // Pipeline register: flush kills the write, stall holds, otherwise capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we        <= 1'b0;
      rf_waddr     <= '0;
      rf_wdata     <= '0;
      retire_count <= '0;
    end else if (flush) begin
      rf_we <= 1'b0;
    end else if (!stall) begin
      rf_we    <= in_valid & in_reg_write & (in_rd != '0);
      rf_waddr <= in_rd;
      rf_wdata <= wb_data;
      if (in_valid) begin
        retire_count <= retire_count + XLEN'(1);
      end
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - directed self-checking bench for mem_wb_stage
module tb_mem_wb_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_reg_write;
  logic [4:0]  in_rd;
  logic [1:0]  in_wb_sel;
  logic [31:0] in_alu_result;
  logic [31:0] in_mem_data;
  logic [31:0] in_pc_plus4;
  logic [31:0] in_imm;
  logic [2:0]  in_funct3;
  logic [1:0]  in_addr_lo;
  logic        stall;
  logic        flush;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] retire_count;

  logic        rf_we8;
  logic [4:0]  rf_waddr8;
  logic [7:0]  rf_wdata8;
  logic [7:0]  retire_count8;

  int errors;
  int checks;
  logic [31:0] exp_count;

  mem_wb_stage #(.XLEN(32), .RADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_reg_write(in_reg_write),
    .in_rd(in_rd), .in_wb_sel(in_wb_sel), .in_alu_result(in_alu_result),
    .in_mem_data(in_mem_data), .in_pc_plus4(in_pc_plus4), .in_imm(in_imm),
    .in_funct3(in_funct3), .in_addr_lo(in_addr_lo), .stall(stall), .flush(flush),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .retire_count(retire_count)
  );

  mem_wb_stage #(.XLEN(8), .RADDR_W(5)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_reg_write(in_reg_write),
    .in_rd(in_rd), .in_wb_sel(in_wb_sel), .in_alu_result(in_alu_result[7:0]),
    .in_mem_data(in_mem_data[7:0]), .in_pc_plus4(in_pc_plus4[7:0]), .in_imm(in_imm[7:0]),
    .in_funct3(in_funct3), .in_addr_lo(in_addr_lo), .stall(stall), .flush(flush),
    .rf_we(rf_we8), .rf_waddr(rf_waddr8), .rf_wdata(rf_wdata8), .retire_count(retire_count8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rw, input logic [4:0] rd, input logic [1:0] sel,
                       input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] pc4,
                       input logic [31:0] imm, input logic [2:0] f3, input logic [1:0] alo);
    in_valid = v; in_reg_write = rw; in_rd = rd; in_wb_sel = sel;
    in_alu_result = alu; in_mem_data = mem; in_pc_plus4 = pc4; in_imm = imm;
    in_funct3 = f3; in_addr_lo = alo;
  endtask

  task automatic test_reset();
    stall = 0; flush = 0;
    drive(1, 1, 5'd3, 2'b00, 32'h1234_5678, 0, 0, 0, 3'b010, 0);
    rst_n = 0;
    #1;
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_we got=%0b exp=0", rf_we); end
    checks++; if (rf_waddr !== 5'd0) begin errors++; $display("FAIL reset_waddr got=%0d exp=0", rf_waddr); end
    checks++; if (rf_wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata got=%h exp=0", rf_wdata); end
    checks++; if (retire_count !== 32'h0) begin errors++; $display("FAIL reset_count got=%0d exp=0", retire_count); end
    step(); step();
    checks++; if (rf_we !== 1'b0 || retire_count !== 32'h0) begin errors++; $display("FAIL reset_held we=%0b cnt=%0d exp=0/0", rf_we, retire_count); end
    rst_n = 1;
    exp_count = 0;
  endtask

  task automatic test_select();
    logic [31:0] vals [4];
    vals[0] = 32'hAAAA_AAAA; vals[1] = 32'hDEAD_BEEF; vals[2] = 32'h0000_0104; vals[3] = 32'hFFFF_F800;
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 5'(i + 1), 2'(i), 32'hAAAA_AAAA, 32'hDEAD_BEEF, 32'h0000_0104, 32'hFFFF_F800, 3'b010, 0);
      step();
      exp_count++;
      checks++; if (rf_wdata !== vals[i]) begin errors++; $display("FAIL select_%0d wdata got=%h exp=%h", i, rf_wdata, vals[i]); end
      checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'(i + 1)) begin errors++; $display("FAIL select_%0d we/addr got=%0b/%0d exp=1/%0d", i, rf_we, rf_waddr, i + 1); end
    end
    checks++; if (retire_count !== 32'd4) begin errors++; $display("FAIL select_count got=%0d exp=4", retire_count); end
  endtask

  task automatic test_load_ext();
    logic [2:0]  f3s  [5];
    logic [1:0]  alos [5];
    logic [31:0] exps [5];
    f3s[0] = 3'b000; alos[0] = 2'd1; exps[0] = 32'hFFFF_FFBE;
    f3s[1] = 3'b100; alos[1] = 2'd3; exps[1] = 32'h0000_00DE;
    f3s[2] = 3'b001; alos[2] = 2'd0; exps[2] = 32'hFFFF_BEEF;
    f3s[3] = 3'b101; alos[3] = 2'd2; exps[3] = 32'h0000_DEAD;
    f3s[4] = 3'b001; alos[4] = 2'd3; exps[4] = 32'hFFFF_DEAD;
`ifndef WB_LOAD_EXT_EN
    for (int i = 0; i < 5; i++) exps[i] = 32'hDEAD_BEEF;
`endif
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 5'd9, 2'b01, 0, 32'hDEAD_BEEF, 0, 0, f3s[i], alos[i]);
      step();
      exp_count++;
      checks++; if (rf_wdata !== exps[i]) begin errors++; $display("FAIL load_%0d wdata got=%h exp=%h", i, rf_wdata, exps[i]); end
    end
    checks++; if (retire_count !== exp_count) begin errors++; $display("FAIL load_count got=%0d exp=%0d", retire_count, exp_count); end
  endtask

  task automatic test_x0();
    drive(1, 1, 5'd0, 2'b00, 32'h5555_5555, 0, 0, 0, 3'b010, 0);
    step();
    exp_count++;
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL x0_we got=%0b exp=0", rf_we); end
    checks++; if (retire_count !== exp_count) begin errors++; $display("FAIL x0_count got=%0d exp=%0d", retire_count, exp_count); end
    drive(1, 0, 5'd4, 2'b00, 32'h5555_5555, 0, 0, 0, 3'b010, 0);
    step();
    exp_count++;
    checks++; if (rf_we !== 1'b0 || retire_count !== exp_count) begin errors++; $display("FAIL norw we=%0b cnt=%0d exp=0/%0d", rf_we, retire_count, exp_count); end
    drive(0, 1, 5'd4, 2'b00, 32'h5555_5555, 0, 0, 0, 3'b010, 0);
    step();
    checks++; if (rf_we !== 1'b0 || retire_count !== exp_count) begin errors++; $display("FAIL bubble we=%0b cnt=%0d exp=0/%0d", rf_we, retire_count, exp_count); end
  endtask

  task automatic test_hazards();
    drive(1, 1, 5'd5, 2'b00, 32'h0000_0011, 0, 0, 0, 3'b010, 0);
    step();
    exp_count++;
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'h11) begin errors++; $display("FAIL haz_cap got=%0b/%0d/%h exp=1/5/00000011", rf_we, rf_waddr, rf_wdata); end
    drive(1, 1, 5'd7, 2'b00, 32'h0000_0099, 0, 0, 0, 3'b010, 0);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'h11 || retire_count !== exp_count)
        begin errors++; $display("FAIL stall_%0d got=%0b/%0d/%h/%0d exp=1/5/00000011/%0d", i, rf_we, rf_waddr, rf_wdata, retire_count, exp_count); end
    end
    flush = 1;
    step();
    checks++; if (rf_we !== 1'b0 || retire_count !== exp_count) begin errors++; $display("FAIL stall_flush we=%0b cnt=%0d exp=0/%0d", rf_we, retire_count, exp_count); end
    stall = 0;
    step();
    checks++; if (rf_we !== 1'b0 || retire_count !== exp_count) begin errors++; $display("FAIL flush we=%0b cnt=%0d exp=0/%0d", rf_we, retire_count, exp_count); end
    flush = 0;
    step();
    exp_count++;
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'h99 || retire_count !== exp_count)
      begin errors++; $display("FAIL resume got=%0b/%0d/%h/%0d exp=1/7/00000099/%0d", rf_we, rf_waddr, rf_wdata, retire_count, exp_count); end
  endtask

  task automatic test_reset_midstream();
    drive(1, 1, 5'd12, 2'b11, 0, 0, 0, 32'hCAFE_0001, 3'b010, 0);
    step();
    checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL mid_pre_we got=%0b exp=1", rf_we); end
    #2;
    rst_n = 0;
    #1;
    checks++; if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'h0 || retire_count !== 32'h0)
      begin errors++; $display("FAIL mid_reset got=%0b/%0d/%h/%0d exp=0/0/0/0", rf_we, rf_waddr, rf_wdata, retire_count); end
    step();
    #3;
    rst_n = 1;
    step();
    exp_count = 1;
    checks++; if (rf_we !== 1'b1 || rf_wdata !== 32'hCAFE_0001 || retire_count !== exp_count)
      begin errors++; $display("FAIL post_reset got=%0b/%h/%0d exp=1/cafe0001/1", rf_we, rf_wdata, retire_count); end
  endtask

  task automatic test_wrap();
    #2;
    rst_n = 0;
    #2;
    rst_n = 1;
    drive(1, 1, 5'd1, 2'b00, 32'h0000_0042, 0, 0, 0, 3'b010, 0);
    for (int i = 0; i < 255; i++) step();
    checks++; if (retire_count8 !== 8'hFF) begin errors++; $display("FAIL wrap_255 got=%h exp=ff", retire_count8); end
    step();
    checks++; if (retire_count8 !== 8'h00) begin errors++; $display("FAIL wrap_256 got=%h exp=00", retire_count8); end
    checks++; if (retire_count !== 32'd256) begin errors++; $display("FAIL wide_256 got=%0d exp=256", retire_count); end
    checks++; if (rf_wdata8 !== 8'h42) begin errors++; $display("FAIL narrow_data got=%h exp=42", rf_wdata8); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    exp_count = 0;
    rst_n = 1;
    stall = 0;
    flush = 0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    test_reset();
    test_select();
    test_load_ext();
    test_x0();
    test_hazards();
    test_reset_midstream();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
